// File: rtl/rc4_pkg.sv
// Shared types and sizes for the RC4 key-search pipeline stages.
package rc4_pkg;

  localparam int MSG_LEN_DEF = 32;
  localparam int S_AW        = 8;
  localparam int MSG_AW      = 5;
  localparam int CNT_W       = 6;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INC_I,
    ST_RD_I,
    ST_CAP_I,
    ST_RD_J,
    ST_CAP_J,
    ST_WR_I,
    ST_WR_J,
    ST_RD_F,
    ST_CAP_F,
    ST_EMIT,
    ST_WAIT_CMP,
    ST_DONE
  } state_t;

  // Successor for the states that advance without a condition.
  function automatic state_t next_seq(input state_t s);
    state_t n;
    case (s)
      ST_INC_I: n = ST_RD_I;
      ST_RD_I:  n = ST_CAP_I;
      ST_CAP_I: n = ST_RD_J;
      ST_RD_J:  n = ST_CAP_J;
      ST_CAP_J: n = ST_WR_I;
      ST_WR_I:  n = ST_WR_J;
      ST_WR_J:  n = ST_RD_F;
      ST_RD_F:  n = ST_CAP_F;
      ST_CAP_F: n = ST_EMIT;
      ST_EMIT:  n = ST_WAIT_CMP;
      default:  n = s;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rc4_decrypt_stage.sv
// RC4 keystream/decrypt loop: one plaintext byte per message position,
// handed to the character checker and held until it is accepted.
module rc4_decrypt_stage
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEF
) (
  input  logic              clok,
  input  logic              reset,
  input  logic              start,
  input  logic              start_over,
  input  logic              compared_char,
  output logic [S_AW-1:0]   s_addr,
  output logic [7:0]        s_wrdata,
  output logic              s_wren,
  input  logic [7:0]        s_rddata,
  output logic [MSG_AW-1:0] rom_addr,
  input  logic [7:0]        rom_rddata,
  output logic [MSG_AW-1:0] dec_addr,
  output logic [7:0]        dec_wrdata,
  output logic              dec_wren,
  output logic [7:0]        char_out,
  output logic              new_char,
  output logic [CNT_W-1:0]  char_count,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(MSG_LEN - 1);

  state_t           r_state;
  logic [7:0]       r_i;
  logic [7:0]       r_j;
  logic [7:0]       r_si;
  logic [7:0]       r_sj;
  logic [CNT_W-1:0] r_k;
  logic [7:0]       r_char;

  logic             w_abort;

  assign w_abort = start_over && (r_state != ST_IDLE);

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of order.
  always_ff @(posedge clok or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_si    <= '0;
      r_sj    <= '0;
      r_k     <= '0;
      r_char  <= '0;
    end else if (w_abort) begin
      r_state <= ST_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_i <= '0;
          r_j <= '0;
          r_k <= '0;
          if (start && !start_over) r_state <= ST_INC_I;
        end
        ST_INC_I: begin
          r_i     <= r_i + 8'd1;
          r_state <= next_seq(r_state);
        end
        ST_CAP_I: begin
          r_si    <= s_rddata;
          r_j     <= r_j + s_rddata;
          r_state <= next_seq(r_state);
        end
        ST_CAP_J: begin
          r_sj    <= s_rddata;
          r_state <= next_seq(r_state);
        end
        ST_CAP_F: begin
          r_char  <= s_rddata ^ rom_rddata;
          r_state <= next_seq(r_state);
        end
        ST_WAIT_CMP: begin
          if (compared_char) begin
            r_k     <= r_k + 1'b1;
            r_state <= (r_k == LAST_K) ? ST_DONE : ST_INC_I;
          end
        end
        ST_DONE: r_state <= ST_DONE;
        default: r_state <= next_seq(r_state);
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    s_addr     = '0;
    s_wrdata   = '0;
    s_wren     = 1'b0;
    rom_addr   = '0;
    dec_addr   = '0;
    dec_wrdata = '0;
    dec_wren   = 1'b0;
    new_char   = 1'b0;
    case (r_state)
      ST_RD_I: s_addr = r_i;
      ST_RD_J: s_addr = r_j;
      ST_WR_I: begin
        s_addr   = r_i;
        s_wrdata = r_sj;
        s_wren   = !start_over;
      end
      ST_WR_J: begin
        s_addr   = r_j;
        s_wrdata = r_si;
        s_wren   = !start_over;
      end
      ST_RD_F: begin
        s_addr   = r_si + r_sj;
        rom_addr = r_k[MSG_AW-1:0];
      end
      ST_EMIT: begin
        new_char   = 1'b1;
        dec_addr   = r_k[MSG_AW-1:0];
        dec_wrdata = r_char;
        dec_wren   = !start_over;
      end
      default: ;
    endcase
  end

  assign char_out   = r_char;
  assign char_count = r_k;
  assign busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done       = (r_state == ST_DONE);

endmodule

// File: doc/rc4_decrypt_stage.md
# rc4_decrypt_stage

- Third loop of the RC4 key-search pipeline; runs after the key-schedule loop has finished permuting S memory for the current key.
- Generates one keystream byte per message position and XORs it with the encrypted ROM byte.
- Writes the plaintext byte to decrypted RAM and presents it to the character checker.
- Waits for the checker's verdict before moving to the next position, and aborts immediately when the checker requests a new key.

## Interface
Parameters:
- MSG_LEN, 32, message length in bytes (1..32)

Ports:
- clok  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: S memory holds the permuted state for the current key
- start_over  in  1  abort from checker: return to IDLE, discard progress
- compared_char  in  1  one-cycle pulse: checker accepted the current char
- s_addr  out  8  S memory address
- s_wrdata  out  8  S memory write data
- s_wren  out  1  S memory write enable
- s_rddata  in  8  S memory read data, valid one clock after s_addr
- rom_addr  out  5  encrypted ROM address
- rom_rddata  in  8  encrypted ROM data, valid one clock after rom_addr
- dec_addr  out  5  decrypted RAM address
- dec_wrdata  out  8  decrypted RAM write data
- dec_wren  out  1  decrypted RAM write enable
- char_out  out  8  current plaintext byte
- new_char  out  1  one-cycle pulse: char_out is valid
- char_count  out  6  current position k (0..MSG_LEN)
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  all MSG_LEN chars accepted

## Operation
Registers: i, j, si, sj (8 b); k (6 b); char_out (8 b).

States and transitions:
- IDLE: i=j=k=0. start=1 and start_over=0 → INC_I.
- INC_I: i<=i+1.
- RD_I: s_addr=i.
- CAP_I: si<=s_rddata; j<=j+s_rddata.
- RD_J: s_addr=j.
- CAP_J: sj<=s_rddata.
- WR_I: s_addr=i, s_wrdata=sj, s_wren=1.
- WR_J: s_addr=j, s_wrdata=si, s_wren=1.
- RD_F: s_addr=si+sj; rom_addr=k.
- CAP_F: char_out<=s_rddata ^ rom_rddata.
- EMIT: new_char=1; dec_addr=k, dec_wrdata=char_out, dec_wren=1. Next state WAIT_CMP.
- WAIT_CMP: on compared_char, k<=k+1; go to DONE if k+1==MSG_LEN, else INC_I. Otherwise hold.
- DONE: done=1, char_count=MSG_LEN; hold until start_over or reset.

Sequencing and priority:
- States from INC_I through CAP_F advance unconditionally, in the order listed.
- start_over=1 in any state other than IDLE → IDLE next cycle. That cycle asserts no s_wren or dec_wren, and clears i, j and k.
- start is ignored outside IDLE, and is ignored while start_over=1.
- compared_char is sampled only in WAIT_CMP and is ignored elsewhere.

Arithmetic:
- i, j and si+sj are 8-bit and wrap mod 256.
- k never exceeds MSG_LEN.

Reset values:
- State IDLE.
- All registers 0.
- All outputs 0: s_wren, dec_wren, new_char, busy, done, char_count, char_out and all addresses.

## Timing
- Write enables, addresses and new_char are combinational decodes of state and registers.
- char_count equals k directly.
- new_char is high in the 10th state after IDLE. It is visible after the 9th rising edge following the edge that samples start.
- Per-char cost: 10 cycles plus the checker's response delay.
- Each state issues at most one S access, so there is no read/write conflict.
- WR_J follows WR_I. If i==j, the second write rewrites the same value.
- Reset mid-operation leaves S memory partially swapped. Recovery is the upstream loops' job.

## Structure
- rc4_pkg:
  - state enum
  - MSG_LEN default
  - widths: S address 8, message address 5, count 6
- Single flat FSM+datapath module; no sub-module.
- The three memories are instantiated at top level.

## Test plan
- Identity S (s[x]=x), ROM all 0x00. Pulse start → first new_char after 9 edges with char_out=0x02 and dec write to addr 0. Pulse compared_char → second char_out=0x05, and S now has s[2]=3, s[3]=2.
- Same setup, ROM[0]=0x41 → char_out=0x43, dec_wrdata=0x43.
- Hold compared_char low for 50 cycles after new_char → state stays WAIT_CMP, no further S/dec writes, new_char pulses exactly once.
- Assert start_over during WR_I of char 3 → no write in that cycle, IDLE next cycle, char_count=0. A new start restarts from i=j=0.
- MSG_LEN=4, answer every new_char with compared_char → exactly 4 new_char pulses, then done=1, char_count=4, busy=0, stable for 100 cycles.
- Assert reset mid-RD_F → all outputs 0 immediately. After release, start is needed before any activity.
